// File: rtl/io_hub_pkg.sv
// io_hub_pkg: shared definitions for the port-mapped I/O hub.
//   - port_id_t          : 8-bit MCU port identifier
//   - IRQ_*_OFS          : offsets of the interrupt-controller ports from IRQ_BASE
//   - IRQ_NONE           : SRC readback value when nothing is pending and enabled
//   - ranges_overlap()   : elaboration helper for the port map sanity checks
package io_hub_pkg;

    typedef logic [7:0] port_id_t;

    localparam int IRQ_MASK_OFS = 0;
    localparam int IRQ_PEND_OFS = 1;
    localparam int IRQ_SRC_OFS  = 2;

    localparam logic [7:0] IRQ_NONE = 8'hFF;

    // Half-open ranges [a, a+na) and [b, b+nb) share at least one port ID.
    function automatic logic ranges_overlap(input int a, input int na,
                                            input int b, input int nb);
        return (a < b + nb) && (b < a + na);
    endfunction

endpackage

// File: rtl/io_port_hub_irq_ctrl.sv
// irq_ctrl: edge-triggered, maskable interrupt controller.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_irq_src       : raw interrupt request lines
//   i_mask_we       : load i_wdata into the mask register
//   i_pend_w1c      : clear pending bits where i_wdata is 1
//   i_wdata         : write data (low N_IRQ bits of the MCU bus)
//   o_mask, o_pend  : register readback
//   o_src_idx       : lowest pending&enabled source index, IRQ_NONE if none
//   o_interrupt     : registered OR of pending&enabled
module irq_ctrl
    import io_hub_pkg::*;
#(
    parameter int N_IRQ    = 4,
    parameter int SYNC_IRQ = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_IRQ-1:0] i_irq_src,
    input  logic             i_mask_we,
    input  logic             i_pend_w1c,
    input  logic [N_IRQ-1:0] i_wdata,
    output logic [N_IRQ-1:0] o_mask,
    output logic [N_IRQ-1:0] o_pend,
    output logic [7:0]       o_src_idx,
    output logic             o_interrupt
);

    logic [N_IRQ-1:0] w_s;
    logic             w_settle;
    logic [N_IRQ-1:0] r_prev, r_mask, r_pend;
    logic             r_int;
    logic [N_IRQ-1:0] w_edge, w_clr, w_pend_nxt, w_mask_nxt, w_act;

    generate
        if (SYNC_IRQ != 0) begin : g_sync
            logic [N_IRQ-1:0] r_sync1, r_sync2;
            // The synchroniser is cleared by reset, so a source held high
            // across reset release would reappear at its output as a fresh
            // rising edge. r_settle keeps edge detection off (prev just
            // follows s) until the flops have refilled with the live level.
            logic [2:0]       r_settle;
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_sync1  <= '0;
                    r_sync2  <= '0;
                    r_settle <= 3'b111;
                end else begin
                    r_sync1  <= i_irq_src;
                    r_sync2  <= r_sync1;
                    r_settle <= {1'b0, r_settle[2:1]};
                end
            end
            assign w_s      = r_sync2;
            assign w_settle = r_settle[0];
        end else begin : g_nosync
            assign w_s      = i_irq_src;
            assign w_settle = 1'b0;
        end
    endgenerate

    assign w_edge     = w_settle ? '0 : (w_s & ~r_prev);
    assign w_clr      = i_pend_w1c ? i_wdata : '0;
    // Set after clear: an edge arriving with a W1C on the same bit survives.
    assign w_pend_nxt = (r_pend & ~w_clr) | w_edge;
    assign w_mask_nxt = i_mask_we ? i_wdata : r_mask;

    always_ff @(posedge i_clk) begin
        // prev tracks s in reset too, so a level already high is not an edge.
        r_prev <= w_s;
        if (i_reset) begin
            r_mask <= '0;
            r_pend <= '0;
            r_int  <= 1'b0;
        end else begin
            r_mask <= w_mask_nxt;
            r_pend <= w_pend_nxt;
            // Registered from next-state so clears/masks drop it on the same edge.
            r_int  <= |(w_pend_nxt & w_mask_nxt);
        end
    end

    assign w_act = r_pend & r_mask;

    always_comb begin
        o_src_idx = IRQ_NONE;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (w_act[k]) o_src_idx = 8'(k);
        end
    end

    assign o_mask      = r_mask;
    assign o_pend      = r_pend;
    assign o_interrupt = r_int;

endmodule

// File: rtl/io_port_hub.sv
// io_port_hub: port-mapped I/O hub for the RAT MCU bus.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_port_id      : MCU port_id
//   i_out_port     : MCU write data
//   i_io_strb      : MCU write strobe (may be held several cycles)
//   o_in_port      : combinational read data to the MCU
//   i_in_data      : N_IN packed input channels, channel j at [8j+7:8j]
//   o_out_data     : N_OUT packed output registers
//   o_out_wr       : one-cycle write pulse per output channel
//   i_irq_src      : interrupt request lines
//   o_interrupt    : interrupt to the MCU
module io_port_hub
    import io_hub_pkg::*;
#(
    parameter int       N_OUT    = 4,
    parameter int       N_IN     = 4,
    parameter int       N_IRQ    = 4,
    parameter port_id_t OUT_BASE = 8'h40,
    parameter port_id_t IN_BASE  = 8'h20,
    parameter port_id_t IRQ_BASE = 8'hF0,
    parameter int       SYNC_IRQ = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_port_id,
    input  logic [7:0]         i_out_port,
    input  logic               i_io_strb,
    output logic [7:0]         o_in_port,
    input  logic [8*N_IN-1:0]  i_in_data,
    output logic [8*N_OUT-1:0] o_out_data,
    output logic [N_OUT-1:0]   o_out_wr,
    input  logic [N_IRQ-1:0]   i_irq_src,
    output logic               o_interrupt
);

    generate
        if (N_OUT < 1 || N_OUT > 16) begin : g_bad_nout
            $error("io_port_hub: N_OUT must be 1..16");
        end
        if (N_IN < 1 || N_IN > 16) begin : g_bad_nin
            $error("io_port_hub: N_IN must be 1..16");
        end
        if (N_IRQ < 1 || N_IRQ > 8) begin : g_bad_nirq
            $error("io_port_hub: N_IRQ must be 1..8");
        end
        if (int'(OUT_BASE) + N_OUT > 256 || int'(IN_BASE) + N_IN > 256 ||
            int'(IRQ_BASE) + 3 > 256) begin : g_bad_wrap
            $error("io_port_hub: port range wraps past 8'hFF");
        end
        if (ranges_overlap(int'(OUT_BASE), N_OUT, int'(IN_BASE), N_IN) ||
            ranges_overlap(int'(OUT_BASE), N_OUT, int'(IRQ_BASE), 3) ||
            ranges_overlap(int'(IN_BASE), N_IN, int'(IRQ_BASE), 3)) begin : g_bad_overlap
            $error("io_port_hub: port ranges overlap");
        end
    endgenerate

    localparam port_id_t PID_MASK = port_id_t'(int'(IRQ_BASE) + IRQ_MASK_OFS);
    localparam port_id_t PID_PEND = port_id_t'(int'(IRQ_BASE) + IRQ_PEND_OFS);
    localparam port_id_t PID_SRC  = port_id_t'(int'(IRQ_BASE) + IRQ_SRC_OFS);

    logic [N_OUT-1:0]      w_wr_req;
    logic [N_OUT-1:0][7:0] r_out_reg;
    logic [N_OUT-1:0]      r_wr_hist;
    logic [N_OUT-1:0]      r_out_wr;
    logic                  w_mask_we, w_pend_w1c;
    logic [N_IRQ-1:0]      w_mask, w_pend;
    logic [7:0]            w_src_idx;
    logic [7:0]            w_rdata;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
            assign w_wr_req[gi] = i_io_strb &&
                                  (i_port_id == port_id_t'(int'(OUT_BASE) + gi));
        end
    endgenerate

    assign w_mask_we  = i_io_strb && (i_port_id == PID_MASK);
    assign w_pend_w1c = i_io_strb && (i_port_id == PID_PEND);

    // Data follows every held-strobe cycle; the pulse fires only on the
    // rising edge of the per-channel request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_reg <= '0;
            r_wr_hist <= '0;
            r_out_wr  <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_wr_req[i]) r_out_reg[i] <= i_out_port;
            end
            r_wr_hist <= w_wr_req;
            r_out_wr  <= w_wr_req & ~r_wr_hist;
        end
    end

    irq_ctrl #(
        .N_IRQ    (N_IRQ),
        .SYNC_IRQ (SYNC_IRQ)
    ) u_irq (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_irq_src   (i_irq_src),
        .i_mask_we   (w_mask_we),
        .i_pend_w1c  (w_pend_w1c),
        .i_wdata     (i_out_port[N_IRQ-1:0]),
        .o_mask      (w_mask),
        .o_pend      (w_pend),
        .o_src_idx   (w_src_idx),
        .o_interrupt (o_interrupt)
    );

    always_comb begin
        w_rdata = 8'h00;
        for (int j = 0; j < N_IN; j++) begin
            if (i_port_id == port_id_t'(int'(IN_BASE) + j)) w_rdata = i_in_data[8*j +: 8];
        end
        for (int i = 0; i < N_OUT; i++) begin
            if (i_port_id == port_id_t'(int'(OUT_BASE) + i)) w_rdata = r_out_reg[i];
        end
        if (i_port_id == PID_MASK) begin
            w_rdata = 8'h00;
            w_rdata[N_IRQ-1:0] = w_mask;
        end
        if (i_port_id == PID_PEND) begin
            w_rdata = 8'h00;
            w_rdata[N_IRQ-1:0] = w_pend;
        end
        if (i_port_id == PID_SRC) w_rdata = w_src_idx;
    end

    assign o_in_port  = w_rdata;
    assign o_out_data = r_out_reg;
    assign o_out_wr   = r_out_wr;

endmodule
